wav_dfi_lp_resp: RTL

- PHY-side DFI low-power handshake responder, directly downstream of the DFI interface; consumes lp_ctrl_req/lp_data_req with their wakeup codes.
- Decides accept or reject per channel, drives lp_ctrl_ack/lp_data_ack back onto the DFI, and gates PHY low-power enables.
- Sequences wake-up exit latency so that each ack falls only after the corresponding req has fallen.
- Control and data channels are two identical, independent FSMs in one module.

---
 rtl/wav_dfi_lp_resp.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/wav_dfi_lp_resp.sv
// PHY-side DFI low-power handshake responder: independent ctrl and data channels,
// each deciding accept/reject, driving ack and the PHY low-power enable, and timing wake-up exit.
module wav_dfi_lp_resp #(
  parameter int ACK_DLY  = 2,
  parameter int TLP_RESP = 8,
  parameter int WK_W     = 6
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            lp_ctrl_req,
  input  logic [WK_W-1:0] lp_ctrl_wakeup,
  input  logic            lp_data_req,
  input  logic [WK_W-1:0] lp_data_wakeup,
  input  logic            cfg_lp_en,
  input  logic [WK_W-1:0] cfg_min_wakeup,
  input  logic            phy_busy,
  output logic            lp_ctrl_ack,
  output logic            lp_data_ack,
  output logic            phy_lp_ctrl_en,
  output logic            phy_lp_data_en,
  output logic [WK_W-1:0] lp_ctrl_wk_lat,
  output logic [WK_W-1:0] lp_data_wk_lat,
  output logic [1:0]      lp_err
);

  localparam int   DLY_W  = $clog2(ACK_DLY + 1);
  localparam int   CNT_W  = (DLY_W > WK_W) ? DLY_W : WK_W;
  localparam logic ACK_OK = (ACK_DLY < TLP_RESP) ? 1'b1 : 1'b0;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DECIDE = 3'd1,
    LP     = 3'd2,
    WAKE   = 3'd3,
    REJECT = 3'd4
  } lp_state_t;

  for (genvar c = 0; c < 2; c++) begin : g_ch
    lp_state_t       state_r, state_nx;
    logic [CNT_W-1:0] cnt_r, cnt_nx;
    logic [WK_W-1:0] lat_r, lat_nx;
    logic            err_r, err_nx;
    logic            ack_r, en_r;
    logic            req_s, accept_s, xwk_s;
    logic [WK_W-1:0] wk_s;

    assign req_s    = (c == 0) ? lp_ctrl_req : lp_data_req;
    assign wk_s     = (c == 0) ? lp_ctrl_wakeup : lp_data_wakeup;
    assign accept_s = cfg_lp_en & ~phy_busy & (wk_s >= cfg_min_wakeup) & ACK_OK;

    // An unknown wakeup code at LP exit is flagged in simulation only.
`ifndef SYNTHESIS
    assign xwk_s = $isunknown(wk_s);
`else
    assign xwk_s = 1'b0;
`endif

    // Next-state, counter, latched wakeup and sticky error for this channel
    always_comb begin
      state_nx = state_r;
      cnt_nx   = cnt_r;
      lat_nx   = lat_r;
      err_nx   = err_r;
      case (state_r)
        IDLE: begin
          if (req_s) begin
            state_nx = DECIDE;
            cnt_nx   = CNT_W'(1);
          end else begin
            cnt_nx = '0;
          end
        end
        DECIDE: begin
          if (!req_s) begin
            state_nx = IDLE;
            cnt_nx   = '0;
          end else if (cnt_r == CNT_W'(ACK_DLY)) begin
            cnt_nx = '0;
            if (accept_s) begin
              state_nx = LP;
              lat_nx   = wk_s;
            end else begin
              state_nx = REJECT;
            end
          end else begin
            cnt_nx = cnt_r + CNT_W'(1);
          end
        end
        LP: begin
          if (req_s) begin
            lat_nx = wk_s;
          end else begin
            state_nx = WAKE;
            cnt_nx   = CNT_W'(lat_r);
            err_nx   = err_r | xwk_s;
          end
        end
        WAKE: begin
          // A request during exit is a protocol violation; it is not serviced here.
          err_nx = err_r | req_s;
          if (cnt_r == '0) begin
            state_nx = IDLE;
          end else begin
            cnt_nx = cnt_r - CNT_W'(1);
          end
        end
        REJECT: begin
          if (!req_s) begin
            state_nx = IDLE;
          end else begin
            state_nx = REJECT;
          end
        end
        default: begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end
      endcase
    end

    // State register with ack/enable registered alongside the state they decode
    always_ff @(posedge clock) begin
      if (!reset) begin
        state_r <= IDLE;
        cnt_r   <= '0;
        lat_r   <= '0;
        err_r   <= 1'b0;
        ack_r   <= 1'b0;
        en_r    <= 1'b0;
      end else begin
        state_r <= state_nx;
        cnt_r   <= cnt_nx;
        lat_r   <= lat_nx;
        err_r   <= err_nx;
        ack_r   <= (state_nx == LP) || (state_nx == WAKE);
        en_r    <= (state_nx == LP);
      end
    end
  end

  assign lp_ctrl_ack    = g_ch[0].ack_r;
  assign lp_data_ack    = g_ch[1].ack_r;
  assign phy_lp_ctrl_en = g_ch[0].en_r;
  assign phy_lp_data_en = g_ch[1].en_r;
  assign lp_ctrl_wk_lat = g_ch[0].lat_r;
  assign lp_data_wk_lat = g_ch[1].lat_r;
  assign lp_err         = {g_ch[1].err_r, g_ch[0].err_r};

endmodule
